keypad_scan: RTL and testbench
==============================

# keypad_scan

Input-side companion to the seven-segment display driver. It scans a 4x4 active-low matrix keypad, synchronises and debounces the row lines, and reports each new key press as a one-cycle event with a 4-bit hex code. It also shifts entered digits into a 32-bit value register, the same word layout the display driver shows, so the CPU and syscall path can read an entered number.

## Interface
- SCAN_DIV, default 1000: clock cycles each column is driven (slot length); legal minimum 4.
- DEBOUNCE, default 4: consecutive identical frame results needed before a state is accepted; legal range 1..15.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- clr  in  1  synchronous clear of value.
- col_out  out  4  column drive, active-low, exactly one bit low at any time.
- key_valid  out  1  one-cycle pulse per accepted new press.
- key_code  out  4  code of the last accepted press; held between presses.
- pressed  out  1  high while the debounced state is "one key down".
- value  out  32  digit shift register; newest digit in [3:0].

## Operation
- Reset values: col_out=4'b1110, key_valid=0, key_code=0, pressed=0, value=0. All internal counters, synchroniser flops, and debounce state also clear.
- Column scan: a slot counter runs 0..SCAN_DIV-1. At wrap, the column index advances 0→1→2→3→0, and col_out drives column c low (bit c=0). Four slots make one frame.
- row_in passes through a 2-flop synchroniser. The synchronised rows are sampled on the last cycle of each slot (slot counter = SCAN_DIV-1).
- Frame result accumulates over the 4 samples:
  - NONE: no row low in any column.
  - KEY(code): exactly one (row r, column c) low in the whole frame, with code = {r[1:0], c[1:0]} = 4r+c.
  - MULTI: more than one low. MULTI is treated as NONE for debouncing, so ghosting and chords are ignored.
- Debounce, evaluated at frame end:
  - If the frame result equals the candidate, increment the match counter, saturating at DEBOUNCE.
  - Otherwise load the new candidate with count=1.
  - When count reaches DEBOUNCE, the candidate becomes the stable state.
- Stable state machine, states IDLE and HELD:
  - IDLE→HELD on stable KEY(x): assert key_valid for one cycle, key_code←x, pressed←1, and value←{value[27:0],x}.
  - HELD→IDLE on stable NONE: pressed←0 and no pulse.
  - HELD with stable KEY(y≠x) produces no event. A different key requires a release first, and auto-repeat is never generated.
- clr: value←0 on the next edge. If clr coincides with a key_valid update, value←{28'h0,x}. clr does not affect key_code, pressed or the scan.
- rst asserted mid-frame or mid-press returns everything to the reset values at once. After release, a key still held is re-detected and does produce one key_valid.

## Timing
- Frame length is 4·SCAN_DIV cycles.
- col_out changes on the clock edge that wraps the slot counter. The row sample falls SCAN_DIV-1 cycles later, which gives the keypad SCAN_DIV-3 settling cycles after synchroniser delay.
- Press latency: from row_in stable low to key_valid, between DEBOUNCE and DEBOUNCE+1 frames plus 3 cycles. key_valid fires in the cycle after the frame-end evaluation.
- key_code, pressed and value update on the same edge that raises key_valid.
- Release latency: pressed falls DEBOUNCE to DEBOUNCE+1 frames after release.
- A bounce shorter than one frame resets the candidate count. It never produces an event unless DEBOUNCE consecutive frames agree.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE=3 (frame=16 cycles). The keypad model pulls row r low while col_out[c]=0 for each pressed key (r,c).

- Reset check: reset, then 3 frames idle → col_out cycles 1110,1101,1011,0111 every 4 cycles, key_valid never high, value=0.
- Single press: hold (r=2,c=1) for 8 frames, then release → exactly one key_valid, key_code=9, pressed high until ~3–4 frames after release.
- Digit entry: press/release keys 1, 2, 15 (r3c3) in turn → value=32'h0000_012F, three pulses total.
- Bounce and chord:
  - Toggle (r0,c0) every 10 cycles for 6 frames → no key_valid.
  - Hold (r0,c0)+(r1,c2) → no key_valid.
  - Release (r1,c2) while still holding (r0,c0) → one pulse with code 0.
- Held-key change: hold key 5, then switch to key 6 without release → one pulse (code 5) only. Release, then press 6 → pulse with code 6.
- Clear and reset corner cases:
  - clr asserted in the key_valid cycle of key 7 with value=32'hAB → value=32'h7.
  - rst asserted mid-press, released while key held → all outputs return to reset values at once, then exactly one new pulse.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with row synchroniser, frame-level
// debounce, one-cycle press events and a 32-bit hex digit shift register.
module keypad_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  input  logic        clr,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        pressed,
  output logic [31:0] value
);

  // state | meaning
  // IDLE  | no key accepted; a stable single key raises an event
  // HELD  | key accepted; wait for a stable release, ignore other keys
  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_MAX   = 4'(DEBOUNCE);

  logic [SW-1:0] slot_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic          slot_end;
  logic          frame_end;

  // Frame accumulator: hit count saturates at 2, which stands for MULTI
  logic [1:0]    acc_n;
  logic [3:0]    acc_code;
  logic [1:0]    samp_n;
  logic [1:0]    samp_row;
  logic [2:0]    sum_n;
  logic [1:0]    tot_n;
  logic [3:0]    tot_code;

  logic          cand_key;
  logic [3:0]    cand_code;
  logic [3:0]    deb_cnt;
  logic          res_key;
  logic          match;
  logic [3:0]    cnt_nxt;
  logic          accept;

  state_t        state;
  state_t        state_nxt;
  logic          fire;
  logic          release_evt;

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (col_idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      col_idx  <= 2'd0;
      col_out  <= 4'b1110;
    end else if (slot_end) begin
      slot_cnt <= '0;
      col_idx  <= col_idx + 2'd1;
      col_out  <= {col_out[2:0], col_out[3]};
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  end

  always_comb begin
    samp_n   = 2'd0;
    samp_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        samp_row = 2'(r);
        if (samp_n != 2'd2) samp_n = samp_n + 2'd1;
      end
    end
    sum_n    = {1'b0, acc_n} + {1'b0, samp_n};
    tot_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    tot_code = (acc_n == 2'd1) ? acc_code : {samp_row, col_idx};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_n    <= 2'd0;
      acc_code <= 4'h0;
    end else if (frame_end) begin
      acc_n    <= 2'd0;
      acc_code <= 4'h0;
    end else if (slot_end) begin
      acc_n    <= tot_n;
      acc_code <= tot_code;
    end
  end

  // MULTI folds into NONE, so chords and ghosting never become candidates
  always_comb begin
    res_key = (tot_n == 2'd1);
    match   = (res_key == cand_key) && (!res_key || (tot_code == cand_code));
    if (!match)
      cnt_nxt = 4'd1;
    else if (deb_cnt == DEB_MAX)
      cnt_nxt = deb_cnt;
    else
      cnt_nxt = deb_cnt + 4'd1;
    accept  = (cnt_nxt == DEB_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_key  <= 1'b0;
      cand_code <= 4'h0;
      deb_cnt   <= 4'd0;
    end else if (frame_end) begin
      cand_key  <= res_key;
      cand_code <= res_key ? tot_code : 4'h0;
      deb_cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fire        = 1'b0;
    release_evt = 1'b0;
    if (frame_end && accept) begin
      case (state)
        IDLE: if (res_key) begin
          state_nxt = HELD;
          fire      = 1'b1;
        end
        HELD: if (!res_key) begin
          state_nxt   = IDLE;
          release_evt = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      pressed   <= 1'b0;
      value     <= 32'h0;
    end else begin
      key_valid <= fire;
      if (fire) begin
        key_code <= tot_code;
        pressed  <= 1'b1;
        value    <= clr ? {28'h0, tot_code} : {value[27:0], tot_code};
      end else begin
        if (release_evt) pressed <= 1'b0;
        if (clr)         value   <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: directed key sequences push expected
// (code, value) pairs; a monitor pops one per key_valid pulse.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in;
  logic        clr;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        pressed;
  logic [31:0] value;

  logic [15:0] keys;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   pulses = 0;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .clr      (clr),
    .col_out  (col_out),
    .key_valid(key_valid),
    .key_code (key_code),
    .pressed  (pressed),
    .value    (value)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key (r,c) pulls row r low while column c is driven
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void expect_pulse(logic [3:0] c, logic [31:0] v);
    exp_t e;
    e.code = c;
    e.val  = v;
    sb.push_back(e);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && key_valid === 1'b1) begin
        pulses++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pulse: got code %h value %h expected no pulse", key_code, value);
        end else begin
          e = sb.pop_front();
          chk("pulse_code", 32'(key_code), 32'(e.code));
          chk("pulse_value", value, e.val);
          chk("pulse_pressed", 32'(pressed), 32'd1);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the first cycle of column 0
  task automatic align();
    logic [3:0] prev;
    int guard = 0;
    do begin
      prev = col_out;
      @(negedge clk);
      guard++;
    end while (!(prev == 4'b0111 && col_out == 4'b1110) && guard < 100);
    if (guard >= 100) chk("align_timeout", 32'(guard), 32'd0);
  endtask

  task automatic tap(input int k);
    keys[k] = 1'b1;
    cyc(128);
    keys = 16'h0;
    cyc(96);
  endtask

  task automatic clear_value();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_value", value, 32'h0);
  endtask

  logic [3:0] exp_cols [4];

  initial begin : stim
    exp_cols[0] = 4'b1110;
    exp_cols[1] = 4'b1101;
    exp_cols[2] = 4'b1011;
    exp_cols[3] = 4'b0111;
    rst  = 1'b1;
    clr  = 1'b0;
    keys = 16'h0;
    cyc(3);
    chk("rst_col_out", 32'(col_out), 32'(4'b1110));
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_key_code", 32'(key_code), 32'd0);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_value", value, 32'h0);
    rst = 1'b0;

    // Idle scan: three frames of column rotation
    align();
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++) begin
        chk("scan_col", 32'(col_out), 32'(exp_cols[c]));
        cyc(4);
      end
    chk("idle_value", value, 32'h0);
    chk("idle_pulses", 32'(pulses), 32'd0);

    // Single press of r2c1, with release latency checks
    expect_pulse(4'h9, 32'h9);
    keys[9] = 1'b1;
    cyc(128);
    keys = 16'h0;
    cyc(32);
    chk("pressed_after_2_frames", 32'(pressed), 32'd1);
    cyc(48);
    chk("pressed_after_5_frames", 32'(pressed), 32'd0);
    chk("code_held", 32'(key_code), 32'h9);
    chk("single_pending", 32'(sb.size()), 32'd0);

    // Digit entry
    clear_value();
    expect_pulse(4'h1, 32'h1);
    tap(1);
    expect_pulse(4'h2, 32'h12);
    tap(2);
    expect_pulse(4'hF, 32'h12F);
    tap(15);
    chk("entry_value", value, 32'h0000_012F);
    chk("entry_pending", 32'(sb.size()), 32'd0);

    // Bounce on r0c0, phased so no three consecutive frames see it down
    align();
    cyc(2);
    for (int i = 0; i < 10; i++) begin
      keys[0] = (i % 2 == 0);
      cyc(10);
    end
    keys = 16'h0;
    cyc(96);
    chk("bounce_pressed", 32'(pressed), 32'd0);

    // Chord then partial release
    keys[0] = 1'b1;
    keys[6] = 1'b1;
    cyc(96);
    chk("chord_pressed", 32'(pressed), 32'd0);
    expect_pulse(4'h0, 32'h12F0);
    keys[6] = 1'b0;
    cyc(96);
    chk("chord_release_pressed", 32'(pressed), 32'd1);
    keys = 16'h0;
    cyc(96);
    chk("chord_pending", 32'(sb.size()), 32'd0);

    // Held key change without release
    expect_pulse(4'h5, 32'h12F05);
    keys[5] = 1'b1;
    cyc(96);
    keys[5] = 1'b0;
    keys[6] = 1'b1;
    cyc(96);
    chk("change_pressed", 32'(pressed), 32'd1);
    chk("change_code", 32'(key_code), 32'h5);
    keys = 16'h0;
    cyc(96);
    expect_pulse(4'h6, 32'h12F056);
    tap(6);
    chk("change_pending", 32'(sb.size()), 32'd0);

    // Build 0xAB, then clr coinciding with the key 7 update edge
    clear_value();
    expect_pulse(4'hA, 32'hA);
    tap(10);
    expect_pulse(4'hB, 32'hAB);
    tap(11);
    chk("ab_value", value, 32'hAB);
    align();
    keys[7] = 1'b1;
    expect_pulse(4'h7, 32'h7);
    cyc(40);
    clr = 1'b1;
    cyc(8);
    clr = 1'b0;
    cyc(2);
    chk("clr_coincide_value", value, 32'h7);
    cyc(80);
    keys = 16'h0;
    cyc(96);
    chk("clr_pending", 32'(sb.size()), 32'd0);

    // Reset mid-press, key still held afterwards
    expect_pulse(4'h3, 32'h73);
    keys[3] = 1'b1;
    cyc(80);
    #2 rst = 1'b1;
    #1;
    chk("midrst_col_out", 32'(col_out), 32'(4'b1110));
    chk("midrst_key_valid", 32'(key_valid), 32'd0);
    chk("midrst_key_code", 32'(key_code), 32'd0);
    chk("midrst_pressed", 32'(pressed), 32'd0);
    chk("midrst_value", value, 32'h0);
    cyc(3);
    rst = 1'b0;
    expect_pulse(4'h3, 32'h3);
    cyc(96);
    keys = 16'h0;
    cyc(96);
    chk("midrst_pressed_end", 32'(pressed), 32'd0);

    chk("final_pending", 32'(sb.size()), 32'd0);
    chk("pulse_total", 32'(pulses), 32'd12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
